// File: rtl/el2_dccm_rmw_ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | el2_dccm_rmw_ctl_pkg : FSM states, store sizes and SECDED helpers    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package el2_dccm_rmw_ctl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Hamming position (3..38, skipping powers of two) holding data bit idx.
  function automatic logic [5:0] secded_pos(input int unsigned idx);
    int unsigned cnt;
    cnt = 0;
    secded_pos = '0;
    for (int unsigned p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) secded_pos = p[5:0];
        cnt++;
      end
    end
  endfunction

  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    size_legal = (size == SIZE_BYTE) ||
                 ((size == SIZE_HALF) && !addr_lo[0]) ||
                 ((size == SIZE_WORD) && (addr_lo == 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/el2_dccm_rmw_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | el2_dccm_rmw_ctl_if : store request / DCCM port bundle               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface el2_dccm_rmw_ctl_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        ecc_disable;
  logic                        req_valid;
  logic                        req_ready;
  logic [DCCM_BITS-1:0]        req_addr;
  logic [1:0]                  req_size;
  logic [31:0]                 req_wdata;
  logic                        rsp_done;
  logic                        rsp_err;
  logic                        dccm_rden;
  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
  logic [7:0]                  sec_count;

  modport slave (
    input  ecc_disable, req_valid, req_addr, req_size, req_wdata, dccm_rd_data_lo,
    output req_ready, rsp_done, rsp_err, dccm_rden, dccm_rd_addr_lo,
           dccm_wren, dccm_wr_addr_lo, dccm_wr_data_lo, sec_count
  );

  modport master (
    output ecc_disable, req_valid, req_addr, req_size, req_wdata, dccm_rd_data_lo,
    input  req_ready, rsp_done, rsp_err, dccm_rden, dccm_rd_addr_lo,
           dccm_wren, dccm_wr_addr_lo, dccm_wr_data_lo, sec_count
  );
endinterface
`default_nettype wire

// File: rtl/el2_dccm_rmw_ctl_secded32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | el2_dccm_secded32 : (39,32) SECDED encode and check/correct          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module el2_dccm_secded32
  import el2_dccm_rmw_ctl_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [6:0]  chk_in,
  output logic [6:0]  chk_out,
  output logic [31:0] data_out,
  output logic        sec,
  output logic        ded
);
  logic [5:0] ham;
  logic [5:0] syndrome;
  logic       parity_err;

  // Each set data bit contributes its codeword position to the Hamming bits.
  always_comb begin
    ham = '0;
    for (int i = 0; i < 32; i++) begin
      if (data_in[i]) ham = ham ^ secded_pos(i);
    end
  end

  assign chk_out    = {(^data_in) ^ (^ham), ham};
  assign syndrome   = ham ^ chk_in[5:0];
  assign parity_err = (^data_in) ^ (^chk_in);
  assign sec        = parity_err;
  assign ded        = !parity_err && (syndrome != 6'd0);

  for (genvar gi = 0; gi < 32; gi++) begin : g_corr
    assign data_out[gi] = data_in[gi] ^ (sec && (syndrome == secded_pos(gi)));
  end

endmodule
`default_nettype wire

// File: rtl/el2_dccm_rmw_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | el2_dccm_rmw_ctl : DCCM sub-word store read-modify-write with SECDED |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module el2_dccm_rmw_ctl
  import el2_dccm_rmw_ctl_pkg::*;
#(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic               clk,
  input  logic               rst,
  el2_dccm_rmw_ctl_if.slave  bus
);
  logic [2:0]           state_q, state_d;
  logic [DCCM_BITS-1:0] addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic [31:0]          data_q, data_d;
  logic [7:0]           sec_count_q, sec_count_d;

  logic [31:0] sd_data_in, sd_data_out, rd_word, merged;
  logic [6:0]  sd_chk_in, sd_chk_out;
  logic        sd_sec, sd_ded, run;
  logic [DCCM_BITS-1:0] word_addr;

  // One SECDED block: checks read data in MERGE, encodes data_q in WRITE.
  always_comb begin
    sd_data_in = data_q;
    sd_chk_in  = '0;
    if (state_q == ST_MERGE) begin
      sd_data_in = bus.dccm_rd_data_lo[31:0];
      sd_chk_in  = bus.dccm_rd_data_lo[38:32];
    end
  end

  el2_dccm_secded32 u_secded (
    .data_in  (sd_data_in),
    .chk_in   (sd_chk_in),
    .chk_out  (sd_chk_out),
    .data_out (sd_data_out),
    .sec      (sd_sec),
    .ded      (sd_ded)
  );

  always_comb begin
    rd_word = bus.ecc_disable ? sd_data_in : sd_data_out;
    merged  = rd_word;
    if (size_q == SIZE_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else                     merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    sec_count_d = sec_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          size_d = bus.req_size;
          data_d = bus.req_wdata;
          if (!size_legal(bus.req_size, bus.req_addr[1:0])) state_d = ST_RESP;
          else if (bus.req_size == SIZE_WORD)                state_d = ST_WRITE;
          else                                               state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_MERGE;
      ST_MERGE: begin
        if (sd_ded && !bus.ecc_disable) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WRITE;
          data_d  = merged;
          if (sd_sec && !bus.ecc_disable && (sec_count_q != 8'hFF))
            sec_count_d = sec_count_q + 8'd1;
        end
      end
      ST_WRITE, ST_RESP: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= SIZE_BYTE;
      data_q      <= '0;
      sec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      sec_count_q <= sec_count_d;
    end
  end

  // Outputs are gated by reset so they read zero for the whole reset window.
  assign run       = !rst;
  assign word_addr = {addr_q[DCCM_BITS-1:2], 2'b00};

  assign bus.req_ready       = run && (state_q == ST_IDLE);
  assign bus.dccm_rden       = run && (state_q == ST_READ);
  assign bus.dccm_wren       = run && (state_q == ST_WRITE);
  assign bus.rsp_done        = run && ((state_q == ST_WRITE) || (state_q == ST_RESP));
  assign bus.rsp_err         = run && (state_q == ST_RESP);
  assign bus.dccm_rd_addr_lo = bus.dccm_rden ? word_addr : '0;
  assign bus.dccm_wr_addr_lo = bus.dccm_wren ? word_addr : '0;
  assign bus.dccm_wr_data_lo = bus.dccm_wren ? DCCM_FDATA_WIDTH'({sd_chk_out, data_q}) : '0;
  assign bus.sec_count       = run ? sec_count_q : 8'h00;

endmodule
`default_nettype wire
